// File: rtl/branch_resolver_pkg.sv
// Shared MIPS definitions for the branch resolver: opcodes, FSM encoding and the
// control-transfer decoder used by both the FSM and the target generator.
package mips_defs;

    localparam int DEFAULT_ADDR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // Wide enough for SQUASH_CYCLES up to 4 (counts SQUASH_CYCLES-1 down to 0).
    localparam int SQ_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        REDIRECT = 2'd2,
        SQUASH   = 2'd3
    } brState_t;

    typedef enum logic [2:0] {
        BK_NONE = 3'd0,
        BK_BEQ  = 3'd1,
        BK_BNE  = 3'd2,
        BK_J    = 3'd3,
        BK_JR   = 3'd4
    } brKind_t;

    function automatic brKind_t decodeBranch(input logic [31:0] instr);
        brKind_t kind;
        kind = BK_NONE;
        case (instr[31:26])
            OP_BEQ:   kind = BK_BEQ;
            OP_BNE:   kind = BK_BNE;
            OP_J:     kind = BK_J;
            OP_RTYPE: kind = (instr[5:0] == FUNCT_JR) ? BK_JR : BK_NONE;
            default:  kind = BK_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/branch_resolver_target_calc.sv
// Combinational redirect target for beq/bne (pc-relative), j (region) and jr (register).
module branch_target_calc
    import mips_defs::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       rsData,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] pcPlus4;
    logic [31:0]       offset32;
    logic [ADDR_W-1:0] branchOffset;
    logic [ADDR_W-1:0] jumpTarget;

    always_comb begin
        pcPlus4      = pc + ADDR_W'(4);
        offset32     = {{14{instruction[15]}}, instruction[15:0], 2'b00};
        branchOffset = ADDR_W'($signed(offset32));
        // j keeps the top PC region of pc+4 and replaces the low 28 bits.
        jumpTarget   = (pcPlus4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({instruction[25:0], 2'b00});

        target = '0;
        case (decodeBranch(instruction))
            BK_BEQ, BK_BNE: target = pcPlus4 + branchOffset;
            BK_J:           target = jumpTarget;
            BK_JR:          target = ADDR_W'(rsData);
            default:        target = '0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves beq/bne/j/jr, issues a one-cycle redirect to nextPC, then squashes
// wrong-path fetches; fetch is stalled whenever the FSM is not IDLE.
module branch_resolver
    import mips_defs::*;
#(
    parameter int SQUASH_CYCLES = 1,
    parameter int ADDR_W        = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instrValid,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       rsData,
    input  logic [31:0]       rtData,
    input  logic              regReady,
    output logic              branch,
    output logic [ADDR_W-1:0] branchAddress,
    output logic              squash,
    output logic              stall,
    output brState_t          fsmState
);

    // Handshake: an instruction is accepted when instrValid is high and stall is low;
    // register operands are taken in READ on the first edge where regReady is high.

    brState_t          state;
    brState_t          nextState;
    logic [31:0]       latchedInstr;
    logic [ADDR_W-1:0] latchedPc;
    brKind_t           latchedKind;
    logic [SQ_CNT_W-1:0] sqCount;

    brKind_t           liveKind;
    logic              taken;
    logic [31:0]       calcInstr;
    logic [ADDR_W-1:0] calcPc;
    logic [ADDR_W-1:0] target;

    logic              branchNext;
    logic              squashNext;
    logic              stallNext;
    logic [ADDR_W-1:0] addrNext;

    assign fsmState = state;

    // j resolves straight from the live fetch; reg-based branches use the latched copy.
    always_comb begin
        calcInstr = (state == IDLE) ? instruction : latchedInstr;
        calcPc    = (state == IDLE) ? pc : latchedPc;
    end

    branch_target_calc #(
        .ADDR_W(ADDR_W)
    ) targetCalc (
        .instruction(calcInstr),
        .pc         (calcPc),
        .rsData     (rsData),
        .target     (target)
    );

    always_comb begin
        liveKind = decodeBranch(instruction);
        taken    = 1'b0;
        case (latchedKind)
            BK_BEQ:  taken = (rsData == rtData);
            BK_BNE:  taken = (rsData != rtData);
            BK_JR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (instrValid) begin
                    case (liveKind)
                        BK_J:                  nextState = REDIRECT;
                        BK_BEQ, BK_BNE, BK_JR: nextState = READ;
                        default:               nextState = IDLE;
                    endcase
                end
            end
            READ: begin
                if (regReady) begin
                    nextState = taken ? REDIRECT : IDLE;
                end
            end
            REDIRECT: nextState = SQUASH;
            SQUASH: begin
                if (sqCount == '0) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        branchNext = (nextState == REDIRECT);
        squashNext = (nextState == SQUASH);
        stallNext  = (nextState != IDLE);
        addrNext   = (nextState == REDIRECT) ? target : branchAddress;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            branch        <= 1'b0;
            branchAddress <= '0;
            squash        <= 1'b0;
            stall         <= 1'b0;
            sqCount       <= '0;
            latchedInstr  <= '0;
            latchedPc     <= '0;
            latchedKind   <= BK_NONE;
        end else begin
            branch        <= branchNext;
            branchAddress <= addrNext;
            squash        <= squashNext;
            stall         <= stallNext;

            if (state == IDLE && instrValid) begin
                latchedInstr <= instruction;
                latchedPc    <= pc;
                latchedKind  <= liveKind;
            end

            if (state == REDIRECT) begin
                sqCount <= SQ_CNT_W'(SQUASH_CYCLES - 1);
            end else if (state == SQUASH && sqCount != '0) begin
                sqCount <= sqCount - SQ_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a vector table of branch transactions plus
// hand-written reset, back-to-back and non-branch stream sequences.
module tb_branch_resolver;
    import mips_defs::*;

    localparam int ADDR_W = 32;
    localparam int SQ = 1;
    localparam int KIND_NONE = 0;
    localparam int KIND_JUMP = 1;
    localparam int KIND_REG  = 2;
    localparam logic [31:0] NOISE_J = 32'h0800_00FF;

    logic              clock = 1'b0;
    logic              reset;
    logic              instrValid;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       rsData;
    logic [31:0]       rtData;
    logic              regReady;
    logic              branch;
    logic [ADDR_W-1:0] branchAddress;
    logic              squash;
    logic              stall;
    brState_t          fsmState;

    int passed = 0;
    int total  = 0;
    logic [31:0] lastAddr = '0;

    typedef struct {
        int          kind;
        logic [31:0] instr;
        logic [31:0] pcVal;
        logic [31:0] rs;
        logic [31:0] rt;
        int          delay;
        logic        taken;
        logic [31:0] addr;
        logic        noise;
    } vec_t;

    vec_t vecs[12];

    branch_resolver #(
        .SQUASH_CYCLES(SQ),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .instrValid   (instrValid),
        .instruction  (instruction),
        .pc           (pc),
        .rsData       (rsData),
        .rtData       (rtData),
        .regReady     (regReady),
        .branch       (branch),
        .branchAddress(branchAddress),
        .squash       (squash),
        .stall        (stall),
        .fsmState     (fsmState)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".branch"}, 32'(branch), 32'd0);
        check({tag, ".squash"}, 32'(squash), 32'd0);
        check({tag, ".stall"},  32'(stall),  32'd0);
        check({tag, ".state"},  32'(fsmState), 32'(IDLE));
        check({tag, ".addr"},   branchAddress, lastAddr);
    endtask

    function automatic vec_t mkVec(input int kind, input logic [31:0] instr, input logic [31:0] pcVal,
                                   input logic [31:0] rs, input logic [31:0] rt, input int delay,
                                   input logic taken, input logic [31:0] addr, input logic noise);
        vec_t v;
        v.kind = kind; v.instr = instr; v.pcVal = pcVal; v.rs = rs; v.rt = rt;
        v.delay = delay; v.taken = taken; v.addr = addr; v.noise = noise;
        return v;
    endfunction

    // Entered and left at a negedge with the DUT in IDLE, so consecutive calls are back-to-back.
    task automatic runVec(input int idx);
        vec_t  v;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        check({tag, ".preStall"}, 32'(stall), 32'd0);
        instrValid  = 1'b1;
        instruction = v.instr;
        pc          = v.pcVal;
        rsData      = v.rs;
        rtData      = v.rt;
        regReady    = (v.delay == 0);
        @(negedge clock);
        instrValid = 1'b0;
        if (v.kind == KIND_NONE) begin
            checkIdle({tag, ".none"});
            return;
        end
        if (v.kind == KIND_REG) begin
            for (int i = 0; i <= v.delay; i++) begin
                check($sformatf("%s.read%0d.stall", tag, i), 32'(stall), 32'd1);
                check($sformatf("%s.read%0d.branch", tag, i), 32'(branch), 32'd0);
                check($sformatf("%s.read%0d.state", tag, i), 32'(fsmState), 32'(READ));
                regReady    = (i >= v.delay);
                instrValid  = v.noise;
                instruction = v.noise ? NOISE_J : v.instr;
                @(negedge clock);
            end
            instrValid = 1'b0;
            regReady   = 1'b0;
        end
        if (v.taken) begin
            lastAddr = v.addr;
            check({tag, ".redir.branch"}, 32'(branch), 32'd1);
            check({tag, ".redir.addr"},   branchAddress, v.addr);
            check({tag, ".redir.stall"},  32'(stall), 32'd1);
            check({tag, ".redir.squash"}, 32'(squash), 32'd0);
            check({tag, ".redir.state"},  32'(fsmState), 32'(REDIRECT));
            instrValid  = v.noise;
            instruction = NOISE_J;
            @(negedge clock);
            for (int i = 0; i < SQ; i++) begin
                check($sformatf("%s.sq%0d.squash", tag, i), 32'(squash), 32'd1);
                check($sformatf("%s.sq%0d.branch", tag, i), 32'(branch), 32'd0);
                check($sformatf("%s.sq%0d.addr", tag, i),   branchAddress, v.addr);
                check($sformatf("%s.sq%0d.stall", tag, i),  32'(stall), 32'd1);
                instrValid = v.noise;
                @(negedge clock);
            end
            instrValid = 1'b0;
        end
        checkIdle({tag, ".done"});
    endtask

    logic [31:0] nonBranch[6];

    initial begin
        reset       = 1'b1;
        instrValid  = 1'b0;
        instruction = '0;
        pc          = '0;
        rsData      = '0;
        rtData      = '0;
        regReady    = 1'b0;

        //                kind       instr         pc            rs            rt           dly tkn addr          noise
        vecs[0]  = mkVec(KIND_JUMP, 32'h0800_0006, 32'h0000_0010, 32'h0,       32'h0,        0, 1, 32'h0000_0018, 0);
        vecs[1]  = mkVec(KIND_REG,  32'h1000_FFFE, 32'h0000_0020, 32'd5,       32'd5,        0, 1, 32'h0000_001C, 0);
        vecs[2]  = mkVec(KIND_REG,  32'h1400_0005, 32'h0000_0100, 32'd7,       32'd7,        0, 0, 32'h0,         0);
        vecs[3]  = mkVec(KIND_REG,  32'h03E0_0008, 32'h0000_0300, 32'h40,      32'h0,        3, 1, 32'h0000_0040, 1);
        vecs[4]  = mkVec(KIND_REG,  32'h1000_0001, 32'hFFFF_FFFC, 32'd9,       32'd9,        0, 1, 32'h0000_0004, 0);
        vecs[5]  = mkVec(KIND_REG,  32'h1000_0010, 32'h0000_0040, 32'd1,       32'd2,        0, 0, 32'h0,         0);
        vecs[6]  = mkVec(KIND_REG,  32'h1400_0003, 32'h0000_0080, 32'd1,       32'd2,        1, 1, 32'h0000_0090, 0);
        vecs[7]  = mkVec(KIND_JUMP, 32'h0BFF_FFFF, 32'hA000_0000, 32'h0,       32'h0,        0, 1, 32'hAFFF_FFFC, 0);
        vecs[8]  = mkVec(KIND_REG,  32'h1000_FFFF, 32'h0000_0200, 32'd3,       32'd3,        0, 1, 32'h0000_0200, 0);
        vecs[9]  = mkVec(KIND_REG,  32'h0000_0008, 32'h0000_0500, 32'h1234_5677, 32'h0,      0, 1, 32'h1234_5677, 0);
        vecs[10] = mkVec(KIND_NONE, 32'h0085_1020, 32'h0000_0600, 32'h0,       32'h0,        0, 0, 32'h0,         0);
        vecs[11] = mkVec(KIND_REG,  32'h1400_FFF0, 32'h0000_0700, 32'd4,       32'd4,        2, 0, 32'h0,         1);

        nonBranch[0] = 32'h8C85_0004;  // lw
        nonBranch[1] = 32'hAC85_0008;  // sw
        nonBranch[2] = 32'h0085_1020;  // add
        nonBranch[3] = 32'h0C00_0010;  // jal is not handled here
        nonBranch[4] = 32'h0080_F809;  // jalr
        nonBranch[5] = 32'h2084_0001;  // addi

        repeat (2) @(negedge clock);
        checkIdle("reset");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            runVec(i);
        end

        // Reset held for two cycles while branch is high.
        instrValid  = 1'b1;
        instruction = 32'h0800_0006;
        pc          = 32'h0000_0010;
        @(negedge clock);
        instrValid = 1'b0;
        check("rstRedir.pre.branch", 32'(branch), 32'd1);
        reset = 1'b1;
        lastAddr = '0;
        @(negedge clock);
        checkIdle("rstRedir.edge1");
        @(negedge clock);
        checkIdle("rstRedir.edge2");
        reset = 1'b0;

        // Reset while squash is high.
        instrValid  = 1'b1;
        instruction = 32'h0800_0040;
        pc          = 32'h0000_0020;
        @(negedge clock);
        instrValid = 1'b0;
        @(negedge clock);
        check("rstSquash.pre.squash", 32'(squash), 32'd1);
        check("rstSquash.pre.addr", branchAddress, 32'h0000_0100);
        reset = 1'b1;
        @(negedge clock);
        checkIdle("rstSquash.edge1");
        reset = 1'b0;

        // Non-branch stream every cycle, with regReady high while IDLE.
        regReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instrValid  = 1'b1;
            instruction = nonBranch[$urandom_range(0, 5)];
            pc          = 32'($urandom_range(0, 32'h3FFF)) << 2;
            @(negedge clock);
            check($sformatf("stream%0d.branch", i), 32'(branch), 32'd0);
            check($sformatf("stream%0d.stall", i), 32'(stall), 32'd0);
            check($sformatf("stream%0d.state", i), 32'(fsmState), 32'(IDLE));
        end
        instrValid = 1'b0;
        regReady   = 1'b0;

        runVec(0);
        runVec(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
